// File: rtl/bitty_issuer.sv
// Instruction issuer for the bitty processor: runs a small program memory through
// the control unit's en_i/en_s/en_c/done handshake and collects each result.
module bitty_issuer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic [15:0]   instruction,
    output logic          en_i,
    output logic          en_s,
    output logic          en_c,
    input  logic          done,
    input  logic [15:0]   d_out,
    output logic [15:0]   result,
    output logic          result_valid,
    output logic          busy,
    output logic          finished,
    output logic          error,
    output logic [AW:0]   issued_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_EN_S, S_EN_C, S_WAIT_DONE, S_NEXT, S_FINISH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_len;
    logic [7:0]    r_timer;
    logic [15:0]   r_instr;
    logic [15:0]   r_result;
    logic          r_finished;
    logic          r_error;
    logic [AW:0]   r_issued;
    logic [AW:0]   w_issued_inc;
    logic [AW:0]   w_len_clamped;
    logic          w_timeout;

    assign w_issued_inc  = r_issued + 1'b1;
    assign w_len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign w_timeout     = (r_timer == 8'(TIMEOUT - 1));

    // Program memory is deliberately not reset so a program survives a reset.
    always_ff @(posedge clk) begin
        if (load_we && r_state == S_IDLE) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (prog_len == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE:     w_next = S_EN_S;
            S_EN_S:      w_next = S_EN_C;
            S_EN_C:      w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (done) begin
                    w_next = S_NEXT;
                end else if (w_timeout) begin
                    w_next = S_FINISH;
                end
            end
            S_NEXT:      w_next = (w_issued_inc == r_len) ? S_FINISH : S_ISSUE;
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_len      <= '0;
            r_timer    <= '0;
            r_instr    <= '0;
            r_result   <= '0;
            r_finished <= 1'b0;
            r_error    <= 1'b0;
            r_issued   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_finished <= 1'b0;
                        r_error    <= 1'b0;
                        r_issued   <= '0;
                        r_pc       <= '0;
                        r_len      <= w_len_clamped;
                    end
                end
                S_ISSUE: r_instr <= r_mem[r_pc];
                S_EN_C:  r_timer <= '0;
                S_WAIT_DONE: begin
                    if (done) begin
                        r_result <= d_out;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_NEXT: begin
                    r_issued <= w_issued_inc;
                    r_pc     <= r_pc + 1'b1;
                end
                S_FINISH: r_finished <= 1'b1;
                default: ;
            endcase
        end
    end

    // The ISSUE cycle presents mem[pc] directly so en_i captures it; the held copy
    // then keeps the bus stable while the control unit decodes during CALC.
    assign instruction  = (r_state == S_ISSUE) ? r_mem[r_pc] : r_instr;
    assign en_i         = (r_state == S_ISSUE);
    assign en_s         = (r_state == S_EN_S);
    assign en_c         = (r_state == S_EN_C);
    assign result_valid = (r_state == S_NEXT);
    assign busy         = (r_state != S_IDLE);
    assign result       = r_result;
    assign finished     = r_finished;
    assign error        = r_error;
    assign issued_count = r_issued;

endmodule
